// File: rtl/reservation_station_pkg.sv
// Shared widths, default geometry and opcode constants for the reservation station.
package reservation_station_pkg;
  localparam int DATA_W      = 32;
  localparam int OP_W        = 7;
  localparam int RS_SIZE_DEF = 16;
  localparam int TAG_W_DEF   = 5;

  localparam logic [OP_W-1:0] OP_ALU_R = 7'h33;
  localparam logic [OP_W-1:0] OP_ALU_I = 7'h13;
endpackage

// File: rtl/reservation_station_if.sv
// Dispatcher -> reservation station issue bus with back-pressure.
interface reservation_station_if import reservation_station_pkg::*; #(
  parameter int TAG_W = TAG_W_DEF
) ();
  logic              to_rs_valid;
  logic [DATA_W-1:0] to_rs_imm;
  logic [DATA_W-1:0] to_rs_pc;
  logic [TAG_W-1:0]  to_rs_Qi;
  logic [TAG_W-1:0]  to_rs_Qj;
  logic [DATA_W-1:0] to_rs_Vi;
  logic [DATA_W-1:0] to_rs_Vj;
  logic [TAG_W-1:0]  to_rs_rd;
  logic [OP_W-1:0]   to_rs_op;
  logic              rs_full;

  modport master (
    output to_rs_valid, to_rs_imm, to_rs_pc, to_rs_Qi, to_rs_Qj,
    output to_rs_Vi, to_rs_Vj, to_rs_rd, to_rs_op,
    input  rs_full
  );

  modport slave (
    input  to_rs_valid, to_rs_imm, to_rs_pc, to_rs_Qi, to_rs_Qj,
    input  to_rs_Vi, to_rs_Vj, to_rs_rd, to_rs_op,
    output rs_full
  );
endinterface

// File: rtl/reservation_station_priority_enc.sv
// Lowest-index set-bit finder; found is low when the mask is empty.
module reservation_station_priority_enc #(
  parameter int N = 16
) (
  input  logic [N-1:0]         mask,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = i[$clog2(N)-1:0];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers renamed ops, snoops ALU/LSB broadcasts, issues
// the lowest-index ready entry to the ALU each cycle.
module reservation_station import reservation_station_pkg::*; #(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                wrong_commit,
  reservation_station_if.slave disp,
  input  logic                alu_valid,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic [TAG_W-1:0]    alu_rob_id,
  input  logic                lsb_valid,
  input  logic [DATA_W-1:0]   lsb_res,
  input  logic [TAG_W-1:0]    lsb_rob_id,
  output logic                ex_en,
  output logic [OP_W-1:0]     ex_op,
  output logic [DATA_W-1:0]   ex_Vi,
  output logic [DATA_W-1:0]   ex_Vj,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [DATA_W-1:0]   ex_pc,
  output logic [TAG_W-1:0]    ex_rob_id
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [TAG_W-1:0] NO_DEP = '0;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] busy_nxt;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE];
  logic [DATA_W-1:0]  pc_q  [RS_SIZE];
  logic [TAG_W-1:0]   qi_q  [RS_SIZE];
  logic [TAG_W-1:0]   qj_q  [RS_SIZE];
  logic [DATA_W-1:0]  vi_q  [RS_SIZE];
  logic [DATA_W-1:0]  vj_q  [RS_SIZE];
  logic [TAG_W-1:0]   rd_q  [RS_SIZE];

  logic [RS_SIZE-1:0] free_mask;
  logic [RS_SIZE-1:0] ready_mask;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   issue_idx;
  logic               free_found;
  logic               issue_found;
  logic [CNT_W-1:0]   free_cnt;
  logic               do_insert;

  logic [TAG_W-1:0]   ins_qi;
  logic [TAG_W-1:0]   ins_qj;
  logic [DATA_W-1:0]  ins_vi;
  logic [DATA_W-1:0]  ins_vj;

  // A zero broadcast tag means "no result" and must never clear a dependency.
  function automatic logic tag_hit(input logic bc_valid, input logic [TAG_W-1:0] bc_tag,
                                   input logic [TAG_W-1:0] q);
    return bc_valid && (bc_tag != NO_DEP) && (bc_tag == q);
  endfunction

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_mask[i]  = !busy[i];
      ready_mask[i] = busy[i] && (qi_q[i] == NO_DEP) && (qj_q[i] == NO_DEP);
      free_cnt      = free_cnt + CNT_W'(!busy[i]);
    end
  end

  reservation_station_priority_enc #(.N(RS_SIZE)) u_free_enc (
    .mask  (free_mask),
    .idx   (free_idx),
    .found (free_found)
  );

  reservation_station_priority_enc #(.N(RS_SIZE)) u_ready_enc (
    .mask  (ready_mask),
    .idx   (issue_idx),
    .found (issue_found)
  );

  // One slot of headroom keeps the dispatcher's already-registered op safe.
  assign disp.rs_full = free_cnt <= (disp.to_rs_valid ? CNT_W'(2) : CNT_W'(1));
  assign do_insert    = disp.to_rs_valid && free_found;

  always_comb begin
    ins_qi = disp.to_rs_Qi;
    ins_vi = disp.to_rs_Vi;
    ins_qj = disp.to_rs_Qj;
    ins_vj = disp.to_rs_Vj;
    if (tag_hit(alu_valid, alu_rob_id, disp.to_rs_Qi)) begin
      ins_qi = NO_DEP;
      ins_vi = alu_res;
    end else if (tag_hit(lsb_valid, lsb_rob_id, disp.to_rs_Qi)) begin
      ins_qi = NO_DEP;
      ins_vi = lsb_res;
    end
    if (tag_hit(alu_valid, alu_rob_id, disp.to_rs_Qj)) begin
      ins_qj = NO_DEP;
      ins_vj = alu_res;
    end else if (tag_hit(lsb_valid, lsb_rob_id, disp.to_rs_Qj)) begin
      ins_qj = NO_DEP;
      ins_vj = lsb_res;
    end
  end

  always_comb begin
    busy_nxt = busy;
    if (issue_found) busy_nxt[issue_idx] = 1'b0;
    if (do_insert)   busy_nxt[free_idx]  = 1'b1;
  end

  // Entry occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else if (wrong_commit) begin
      busy <= '0;
    end else if (rdy) begin
      busy <= busy_nxt;
    end
  end

  // Entry payload: wakeup snoop and insert; meaningful only while busy
  always_ff @(posedge clk) begin
    if (rdy && !wrong_commit) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          if (tag_hit(alu_valid, alu_rob_id, qi_q[i])) begin
            qi_q[i] <= NO_DEP;
            vi_q[i] <= alu_res;
          end else if (tag_hit(lsb_valid, lsb_rob_id, qi_q[i])) begin
            qi_q[i] <= NO_DEP;
            vi_q[i] <= lsb_res;
          end
          if (tag_hit(alu_valid, alu_rob_id, qj_q[i])) begin
            qj_q[i] <= NO_DEP;
            vj_q[i] <= alu_res;
          end else if (tag_hit(lsb_valid, lsb_rob_id, qj_q[i])) begin
            qj_q[i] <= NO_DEP;
            vj_q[i] <= lsb_res;
          end
        end
      end
      if (do_insert) begin
        op_q[free_idx]  <= disp.to_rs_op;
        imm_q[free_idx] <= disp.to_rs_imm;
        pc_q[free_idx]  <= disp.to_rs_pc;
        rd_q[free_idx]  <= disp.to_rs_rd;
        qi_q[free_idx]  <= ins_qi;
        qj_q[free_idx]  <= ins_qj;
        vi_q[free_idx]  <= ins_vi;
        vj_q[free_idx]  <= ins_vj;
      end
    end
  end

  // Issue register toward the ALU
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_en     <= 1'b0;
      ex_op     <= '0;
      ex_Vi     <= '0;
      ex_Vj     <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
      ex_rob_id <= '0;
    end else if (wrong_commit || !rdy) begin
      ex_en <= 1'b0;
    end else begin
      ex_en <= issue_found;
      if (issue_found) begin
        ex_op     <= op_q[issue_idx];
        ex_Vi     <= vi_q[issue_idx];
        ex_Vj     <= vj_q[issue_idx];
        ex_imm    <= imm_q[issue_idx];
        ex_pc     <= pc_q[issue_idx];
        ex_rob_id <= rd_q[issue_idx];
      end
    end
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the dispatcher→RS issue interface.
- Buffers non-load/store instructions renamed to ROB tags and snoops the ALU and LSB result broadcasts to wake up waiting operands.
- Each cycle, issues one ready entry to the ALU.
- Sits between the dispatcher (upstream) and the ALU (downstream); the ROB tag is the result identifier throughout.

Parameters:
- RS_SIZE, 16, number of entries; power of two, ≥ 4.
- TAG_W, 5, ROB tag width; tag 0 means "value present, no dependency".

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-low (asserted at 0).
- rdy  in  1  global enable; when 0, no state changes.
- wrong_commit  in  1  mispredict flush.
- to_rs_valid  in  1  dispatch strobe, one entry per high cycle.
- to_rs_imm  in  32  immediate.
- to_rs_pc  in  32  instruction PC.
- to_rs_Qi  in  TAG_W  tag of operand 1 (0 = ready).
- to_rs_Qj  in  TAG_W  tag of operand 2 (0 = ready).
- to_rs_Vi  in  32  operand 1 value, valid when Qi = 0.
- to_rs_Vj  in  32  operand 2 value, valid when Qj = 0.
- to_rs_rd  in  TAG_W  destination ROB tag.
- to_rs_op  in  7  opcode.
- rs_full  out  1  back-pressure to the dispatcher.
- alu_valid  in  1  ALU result broadcast.
- alu_res  in  32  ALU result value.
- alu_rob_id  in  TAG_W  ALU result tag.
- lsb_valid  in  1  LSB result broadcast.
- lsb_res  in  32  LSB result value.
- lsb_rob_id  in  TAG_W  LSB result tag.
- ex_en  out  1  ALU issue strobe, one cycle.
- ex_op  out  7  issued opcode.
- ex_Vi  out  32  issued operand 1.
- ex_Vj  out  32  issued operand 2.
- ex_imm  out  32  issued immediate.
- ex_pc  out  32  issued PC.
- ex_rob_id  out  TAG_W  issued destination tag.

Behaviour:
- Reset (rst=0, asynchronous): all entries free; ex_en=0; all ex_* outputs 0; rs_full=0.
- Entry fields: busy, op, imm, pc, Qi, Qj, Vi, Vj, rd.
- Entry ready: busy && Qi==0 && Qj==0, computed from registered state only.
- Insert (rdy=1, to_rs_valid=1):
  - Target is the lowest-index free entry.
  - Operand forwarding at insert: if incoming Qi≠0 and a broadcast with a matching nonzero tag is valid this cycle, store Qi=0 and Vi=broadcast value. ALU broadcast has priority over LSB when both match. Same rule for Qj.
- Wakeup: every busy entry with Qx≠0 matching a valid nonzero broadcast tag takes Qx=0 and Vx=value at this edge. The entry is eligible for issue the next cycle.
- Issue:
  - Each rdy=1 cycle, the lowest-index ready entry is selected.
  - At the edge: ex_* are loaded from it, ex_en=1, and the entry's busy is cleared.
  - No ready entry: ex_en=0, and ex_* hold their previous values.
  - ex_en is never high for two consecutive cycles for the same entry.
- Latency: operands ready at dispatch, with to_rs_valid high in cycle C → ex_en high in cycle C+2.
- An entry inserted this edge cannot issue at the same edge.
- Insert and issue in the same cycle are both performed.
- rs_full:
  - Combinational from registered state: asserted when the number of free entries, less one if to_rs_valid is high, is ≤ 1.
  - This covers the dispatcher's one-cycle registered latency: an in-flight dispatch always finds a free slot.
  - to_rs_valid while no entry is free is a protocol violation; the bench asserts it never occurs.
- wrong_commit=1 (synchronous, beats rdy): all busy cleared, ex_en=0 at that edge. Insert, wakeup and issue in that cycle are discarded.
- rdy=0: entries, ex_* and wakeup state all hold; ex_en forced to 0 at that edge. Broadcasts arriving while rdy=0 are lost; upstream guarantees none occur.
- Broadcast tag 0 never wakes anything.

Decomposition:
- Shared header const_def.v: RS_SIZE, TAG_W, ROB-tag-zero constant, opcode constants.
- One sub-module, rs_priority_enc: parameterised lowest-index-set-bit finder with found flag. Instantiated twice, once for the free mask and once for the ready mask.

Test Plan:
- Reset mid-operation: 5 entries busy, drive rst=0 for 1 cycle → ex_en=0, rs_full=0 immediately. After release, a ready dispatch issues normally with no stale entry issuing.
- Ready dispatch: to_rs_valid with Qi=Qj=0, Vi=5, Vj=7, rd=3, op=0x33 in cycle C → cycle C+2 ex_en=1, ex_Vi=5, ex_Vj=7, ex_rob_id=3, then ex_en=0.
- Wakeup: dispatch Qi=4, Qj=0, Vj=9; three cycles later alu_valid=1, alu_rob_id=4, alu_res=0x100 → ex_en=1 the cycle after next with ex_Vi=0x100, ex_Vj=9.
- Insert-time forwarding: to_rs_valid with Qj=6 in the same cycle as lsb_valid=1, lsb_rob_id=6, lsb_res=0xDEAD → issues at C+2 with ex_Vj=0xDEAD.
- Fill: RS_SIZE=16, dispatch dependent entries waiting on tag 31 one per cycle → rs_full rises while 14 entries are occupied and 1 insert is pending. Broadcast tag 31 → entries issue one per cycle in index order; rs_full drops.
- Flush: 8 busy entries, two ready; wrong_commit=1 → ex_en=0 next cycle and no later issue without a new dispatch; rs_full=0.
